// File: rtl/display_port.sv
// Memory-mapped display output port: buffers CPU writes in a small FIFO and
// presents each value for HOLD cycles so rapid writes remain visible.
module display_port #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned HOLD   = 16,
  parameter logic [WORD_W-1:0] PORT_ADDR = WORD_W'('hFE),
  parameter logic [WORD_W-1:0] CTRL_ADDR = WORD_W'('hFF)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WORD_W-1:0]        address,
  input  logic [WORD_W-1:0]        sysbus,
  input  logic                     CS,
  input  logic                     R_NW,
  output logic [WORD_W-1:0]        display,
  output logic                     showing,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic {IDLE, SHOW} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               showing_nxt;
  logic               pop_c;

  logic [WORD_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               wr_q;

  logic               wr_c, accept_c, push_req_c, push_c, drop_c, ctrl_c;

  // Only the first cycle of a write strobe counts; fullness uses the pre-edge level.
  assign wr_c       = CS & ~R_NW;
  assign accept_c   = wr_c & ~wr_q;
  assign push_req_c = accept_c && (address == PORT_ADDR);
  assign push_c     = push_req_c && (level < LVL_W'(DEPTH));
  assign drop_c     = push_req_c && !push_c;
  assign ctrl_c     = accept_c && (address == CTRL_ADDR);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Display sequencing: pop a value, then hold it for HOLD cycles.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    showing_nxt = 1'b0;
    pop_c       = 1'b0;
    case (state)
      IDLE: begin
        if (level != '0) begin
          pop_c       = 1'b1;
          cnt_nxt     = CNT_W'(HOLD - 1);
          showing_nxt = 1'b1;
          state_nxt   = SHOW;
        end
      end
      SHOW: begin
        showing_nxt = 1'b1;
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else if (level != '0) begin
          pop_c   = 1'b1;
          cnt_nxt = CNT_W'(HOLD - 1);
        end else begin
          showing_nxt = 1'b0;
          state_nxt   = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (push_c) mem[wr_ptr] <= sysbus;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      display  <= '0;
      showing  <= 1'b0;
      cnt      <= '0;
    end else begin
      wr_q    <= wr_c;
      cnt     <= cnt_nxt;
      showing <= showing_nxt;
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        display <= mem[rd_ptr];
      end
      case ({push_c, pop_c})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      // A drop on the same edge as a clear leaves the flag set.
      if (drop_c)      overflow <= 1'b1;
      else if (ctrl_c) overflow <= 1'b0;
    end
  end

endmodule
